spi_xfer_ctrl: RTL and testbench

SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

---
 rtl/spi_xfer_ctrl_if.sv | 54 +++++
 rtl/spi_xfer_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_xfer_ctrl_if.sv
// Bundle of request, configuration, status and SPI pin signals for the
// spi_xfer_ctrl transfer controller.
//
//   slave  : the controller itself (receives requests and MISO, drives the
//            SPI pins and status).
//   master : the requesting agent (drives requests, configuration and MISO).
//
// Signals:
//   start_i / start_ready_o   transfer request / controller idle
//   tx_data_i[31:0]           word to transmit, right-aligned
//   len_i[1:0]                00=8, 01=16, 10/11=32 bits
//   div_i[DIV_W-1:0]          SCLK half-period = div_i+1 clocks
//   cpol_i, cpha_i            SPI mode
//   lsb_first_i               bit order
//   abort_i                   terminate the current transfer
//   sclk_o, mosi_o, miso_i    SPI serial pins
//   cs_n_o                    chip select, active-low
//   busy_o, done_o, aborted_o status / completion pulse / abort qualifier
//   rx_data_o[31:0]           received word, right-aligned, zero-extended
interface spi_xfer_ctrl_if #(
  parameter int unsigned DIV_W = 4
);
  logic             start_i;
  logic             start_ready_o;
  logic [31:0]      tx_data_i;
  logic [1:0]       len_i;
  logic [DIV_W-1:0] div_i;
  logic             cpol_i;
  logic             cpha_i;
  logic             lsb_first_i;
  logic             abort_i;
  logic             sclk_o;
  logic             mosi_o;
  logic             miso_i;
  logic             cs_n_o;
  logic             busy_o;
  logic             done_o;
  logic             aborted_o;
  logic [31:0]      rx_data_o;

  modport slave (
    input  start_i, tx_data_i, len_i, div_i, cpol_i, cpha_i, lsb_first_i,
           abort_i, miso_i,
    output start_ready_o, sclk_o, mosi_o, cs_n_o, busy_o, done_o,
           aborted_o, rx_data_o
  );

  modport master (
    output start_i, tx_data_i, len_i, div_i, cpol_i, cpha_i, lsb_first_i,
           abort_i, miso_i,
    input  start_ready_o, sclk_o, mosi_o, cs_n_o, busy_o, done_o,
           aborted_o, rx_data_o
  );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// SPI single-word transfer controller (SPI master side).
//
// A start handshake (start_i && start_ready_o) latches the word, length,
// clock divider, mode and bit order. The transfer then walks through
// SETUP (chip select asserted, one half-period), SHIFT (2*N SCLK toggles),
// HOLD (one half-period) and DONE (one-cycle done_o pulse) before
// returning to IDLE. abort_i during SETUP/SHIFT/HOLD jumps straight to DONE
// with aborted_o set and rx_data_o left untouched.
//
// Ports:
//   spi_clock_i  system clock
//   spi_reset_i  asynchronous active-low reset
//   bus          spi_xfer_ctrl_if.slave (request, config, SPI pins, status)
module spi_xfer_ctrl #(
  parameter int unsigned DIV_W = 4
) (
  input logic           spi_clock_i,
  input logic           spi_reset_i,
  spi_xfer_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_DONE
  } state_t;

  // Bit count for an encoded length.
  function automatic logic [5:0] len_bits(input logic [1:0] len);
    case (len)
      2'b00:   return 6'd8;
      2'b01:   return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  // Word bit position of the k-th transmitted (or received) bit.
  function automatic logic [4:0] bit_pos(input logic [5:0] k,
                                         input logic [5:0] n,
                                         input logic       lsb);
    logic [5:0] r;
    r = lsb ? k : (n - 6'd1 - k);
    return r[4:0];
  endfunction

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [5:0]       edge_q, edge_d;
  logic [31:0]      tx_q, tx_d;
  logic [1:0]       len_q, len_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic             lsb_q, lsb_d;
  logic [31:0]      rx_sr_q, rx_sr_d;
  logic [31:0]      rx_data_q, rx_data_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             cs_n_q, cs_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  logic [5:0] nbits;
  logic [5:0] last_edge;
  logic [5:0] bit_k;
  logic       leading;
  logic [4:0] cur_pos;
  logic [4:0] next_pos;
  logic [4:0] first_pos;
  logic       cnt_zero;
  logic       in_xfer_q;
  logic       in_xfer_d;

  assign nbits     = len_bits(len_q);
  assign last_edge = 6'({nbits, 1'b0} - 7'd1);
  assign bit_k     = {1'b0, edge_q[5:1]};
  assign leading   = ~edge_q[0];
  assign cur_pos   = bit_pos(bit_k, nbits, lsb_q);
  assign next_pos  = bit_pos(bit_k + 6'd1, nbits, lsb_q);
  assign first_pos = bit_pos(6'd0, len_bits(bus.len_i), bus.lsb_first_i);
  assign cnt_zero  = (cnt_q == '0);
  assign in_xfer_q = (state_q == S_SETUP) || (state_q == S_SHIFT) ||
                     (state_q == S_HOLD);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    edge_d    = edge_q;
    tx_d      = tx_q;
    len_d     = len_q;
    div_d     = div_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    aborted_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          state_d = S_SETUP;
          tx_d    = bus.tx_data_i;
          len_d   = bus.len_i;
          div_d   = bus.div_i;
          cpol_d  = bus.cpol_i;
          cpha_d  = bus.cpha_i;
          lsb_d   = bus.lsb_first_i;
          cnt_d   = bus.div_i;
          edge_d  = '0;
          rx_sr_d = '0;
          sclk_d  = bus.cpol_i;
          // With cpha=0 the first bit must be valid before the first edge.
          mosi_d  = bus.cpha_i ? 1'b0 : bus.tx_data_i[first_pos];
        end
      end

      S_SETUP: begin
        if (cnt_zero) begin
          state_d = S_SHIFT;
          cnt_d   = div_q;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end

      S_SHIFT: begin
        if (cnt_zero) begin
          sclk_d = ~sclk_q;
          cnt_d  = div_q;
          edge_d = edge_q + 6'd1;
          // Sample on leading edges for cpha=0, trailing edges for cpha=1.
          if (leading != cpha_q) begin
            rx_sr_d[cur_pos] = bus.miso_i;
          end
          if (cpha_q && leading) begin
            mosi_d = tx_q[cur_pos];
          end else if (!cpha_q && !leading && ((bit_k + 6'd1) < nbits)) begin
            mosi_d = tx_q[next_pos];
          end
          if (edge_q == last_edge) begin
            state_d = S_HOLD;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end

      S_HOLD: begin
        if (cnt_zero) begin
          state_d   = S_DONE;
          rx_data_d = rx_sr_q;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides whatever the active state computed this cycle.
    if (bus.abort_i && in_xfer_q) begin
      state_d   = S_DONE;
      sclk_d    = cpol_q;
      rx_data_d = rx_data_q;
      aborted_d = 1'b1;
    end

    in_xfer_d = (state_d == S_SETUP) || (state_d == S_SHIFT) ||
                (state_d == S_HOLD);
    if (!in_xfer_d) begin
      mosi_d = 1'b0;
    end
    cs_n_d = ~in_xfer_d;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge spi_clock_i or negedge spi_reset_i) begin
    if (!spi_reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      edge_q    <= '0;
      tx_q      <= '0;
      len_q     <= '0;
      div_q     <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      tx_q      <= tx_d;
      len_q     <= len_d;
      div_q     <= div_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      lsb_q     <= lsb_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign bus.start_ready_o = (state_q == S_IDLE);
  assign bus.sclk_o        = sclk_q;
  assign bus.mosi_o        = mosi_q;
  assign bus.cs_n_o        = cs_n_q;
  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;
  assign bus.aborted_o     = aborted_q;
  assign bus.rx_data_o     = rx_data_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl: directed scenarios plus randomized
// transfers checked against a behavioural SPI slave/observer model.
module tb_spi_xfer_ctrl;
  localparam int unsigned DIV_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_xfer_ctrl_if #(.DIV_W(DIV_W)) bus ();

  spi_xfer_ctrl #(.DIV_W(DIV_W)) dut (
    .spi_clock_i (clk),
    .spi_reset_i (rst_n),
    .bus         (bus.slave)
  );

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  // Behavioural SPI slave: either loops MOSI back or shifts out sw_v in the
  // configured bit order, advancing after each sampling edge it observes.
  logic        loop_v  = 1'b1;
  logic [31:0] sw_v    = '0;
  int unsigned slave_k = 0;
  int unsigned cur_n   = 8;
  logic        cur_lsb = 1'b0;

  // Word bit position of the k-th bit on the wire.
  function automatic logic [4:0] tx_pos(input int unsigned k,
                                        input int unsigned n,
                                        input logic lsb);
    int unsigned r;
    r = lsb ? k : (n - 1 - k);
    return r[4:0];
  endfunction

  assign bus.miso_i = loop_v ? bus.mosi_o : sw_v[tx_pos(slave_k, cur_n, cur_lsb)];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_xfer(input logic [31:0] tx, input logic [1:0] len,
                         input logic [3:0] dv, input logic cpol,
                         input logic cpha, input logic lsb, input logic loop,
                         input logic [31:0] sw, input logic hold_start,
                         input logic abort_with_start);
    int unsigned n, hp, t_exp, cyc, toggles, bad_time, bad_cs, rx_moves, k;
    logic [31:0] mask, exp_rx, exp_seq, got_seq, rx0;
    logic        prev_sclk;
    n      = (len == 2'd0) ? 8 : (len == 2'd1) ? 16 : 32;
    mask   = (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    hp     = int'(dv) + 1;
    t_exp  = 2 * n * hp + 2 * hp + 1;
    exp_rx = (loop ? tx : sw) & mask;
    exp_seq = '0;
    for (int unsigned i = 0; i < n; i++) exp_seq[i] = tx[tx_pos(i, n, lsb)];

    loop_v = loop; sw_v = sw; cur_n = n; cur_lsb = lsb; slave_k = 0;
    bus.tx_data_i   = tx;
    bus.len_i       = len;
    bus.div_i       = dv;
    bus.cpol_i      = cpol;
    bus.cpha_i      = cpha;
    bus.lsb_first_i = lsb;
    bus.abort_i     = abort_with_start;
    bus.start_i     = 1'b1;
    rx0 = bus.rx_data_o;

    @(posedge clk); #1;
    bus.abort_i = 1'b0;
    if (!hold_start) begin
      bus.start_i     = 1'b0;
      bus.tx_data_i   = $urandom;
      bus.len_i       = 2'($urandom);
      bus.div_i       = 4'($urandom);
      bus.cpol_i      = 1'($urandom);
      bus.cpha_i      = 1'($urandom);
      bus.lsb_first_i = 1'($urandom);
    end
    chk("hs_busy", 32'(bus.busy_o), 32'd1);

    cyc = 1; toggles = 0; prev_sclk = cpol; bad_time = 0; bad_cs = 0;
    rx_moves = 0; got_seq = '0;
    while (!bus.done_o && cyc < t_exp + 64) begin
      if (bus.sclk_o != prev_sclk) begin
        toggles++;
        prev_sclk = bus.sclk_o;
        if (cyc != hp * (toggles + 1) + 1) bad_time++;
        // Odd toggles are leading edges; sampling edge depends on cpha.
        if (((toggles % 2) == 1) != cpha) begin
          k = (toggles - 1) / 2;
          if (k < 32) got_seq[k] = bus.mosi_o;
          slave_k = k + 1;
        end
      end
      if (bus.cs_n_o !== 1'b0) bad_cs++;
      if (bus.rx_data_o !== rx0) rx_moves++;
      @(posedge clk); #1;
      cyc++;
    end

    chk("done_latency", 32'(cyc), 32'(t_exp));
    chk("done", 32'(bus.done_o), 32'd1);
    chk("aborted_clear", 32'(bus.aborted_o), 32'd0);
    chk("sclk_toggles", 32'(toggles), 32'(2 * n));
    chk("sclk_timing", 32'(bad_time), 32'd0);
    chk("cs_low_during", 32'(bad_cs), 32'd0);
    chk("rx_hold_during", 32'(rx_moves), 32'd0);
    chk("mosi_seq", got_seq, exp_seq);
    chk("rx_data", bus.rx_data_o, exp_rx);
    chk("cs_high_done", 32'(bus.cs_n_o), 32'd1);
    chk("sclk_idle", 32'(bus.sclk_o), 32'(cpol));
    chk("mosi_idle", 32'(bus.mosi_o), 32'd0);

    @(posedge clk); #1;
    chk("done_pulse", 32'(bus.done_o), 32'd0);
    chk("ready_after", 32'(bus.start_ready_o), 32'd1);
    chk("busy_after", 32'(bus.busy_o), 32'd0);
    chk("cs_high_idle", 32'(bus.cs_n_o), 32'd1);
    chk("rx_keep", bus.rx_data_o, exp_rx);
  endtask

  task automatic do_abort(input logic [3:0] dv, input logic cpol,
                          input logic cpha);
    int unsigned toggles, cyc;
    logic        prev_sclk;
    logic [31:0] rx0;
    loop_v = 1'b1; cur_n = 8; cur_lsb = 1'b0; slave_k = 0;
    bus.tx_data_i   = $urandom;
    bus.len_i       = 2'd0;
    bus.div_i       = dv;
    bus.cpol_i      = cpol;
    bus.cpha_i      = cpha;
    bus.lsb_first_i = 1'b0;
    bus.start_i     = 1'b1;
    rx0 = bus.rx_data_o;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    toggles = 0; cyc = 0; prev_sclk = cpol;
    // Run until bits 0..4 are complete, i.e. inside bit 5.
    while (toggles < 10 && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.sclk_o != prev_sclk) begin
        toggles++;
        prev_sclk = bus.sclk_o;
      end
    end
    chk("abort_reach", 32'(toggles), 32'd10);
    bus.abort_i = 1'b1;
    @(posedge clk); #1;
    bus.abort_i = 1'b0;
    chk("abort_done", 32'(bus.done_o), 32'd1);
    chk("abort_flag", 32'(bus.aborted_o), 32'd1);
    chk("abort_cs", 32'(bus.cs_n_o), 32'd1);
    chk("abort_sclk", 32'(bus.sclk_o), 32'(cpol));
    chk("abort_mosi", 32'(bus.mosi_o), 32'd0);
    chk("abort_rx", bus.rx_data_o, rx0);
    @(posedge clk); #1;
    chk("abort_done_pulse", 32'(bus.done_o), 32'd0);
    chk("abort_flag_clear", 32'(bus.aborted_o), 32'd0);
    chk("abort_ready", 32'(bus.start_ready_o), 32'd1);
    chk("abort_rx_keep", bus.rx_data_o, rx0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sclk"}, 32'(bus.sclk_o), 32'd0);
    chk({tag, "_mosi"}, 32'(bus.mosi_o), 32'd0);
    chk({tag, "_cs"}, 32'(bus.cs_n_o), 32'd1);
    chk({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
    chk({tag, "_done"}, 32'(bus.done_o), 32'd0);
    chk({tag, "_aborted"}, 32'(bus.aborted_o), 32'd0);
    chk({tag, "_rx"}, bus.rx_data_o, 32'd0);
    chk({tag, "_ready"}, 32'(bus.start_ready_o), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned toggles, cyc;
    logic        prev_sclk;
    rst_n           = 1'b0;
    bus.start_i     = 1'b0;
    bus.tx_data_i   = '0;
    bus.len_i       = '0;
    bus.div_i       = '0;
    bus.cpol_i      = 1'b0;
    bus.cpha_i      = 1'b0;
    bus.lsb_first_i = 1'b0;
    bus.abort_i     = 1'b0;
    #22;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Mode 0, div 0, 8 bits, 0xA5 loopback.
    do_xfer(32'h0000_00A5, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,
            1'b0, 1'b0);
    // Mode 3, div 3, 16 bits LSB first, MISO tied high.
    do_xfer(32'h0000_1234, 2'd1, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF,
            1'b0, 1'b0);
    // Back-to-back 32-bit transfers with start held high.
    do_xfer(32'hDEAD_BEEF, 2'd2, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,
            1'b1, 1'b0);
    do_xfer(32'hDEAD_BEEF, 2'd2, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,
            1'b0, 1'b0);
    // Abort in bit 5 of an 8-bit transfer.
    do_abort(4'd1, 1'b0, 1'b0);
    do_abort(4'd0, 1'b1, 1'b1);
    // Abort together with start in IDLE: start wins.
    do_xfer(32'h0000_3C5A, 2'd1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_9966,
            1'b0, 1'b1);

    // Asynchronous reset in the middle of SHIFT.
    loop_v = 1'b1; cur_n = 8; cur_lsb = 1'b0; slave_k = 0;
    bus.tx_data_i = 32'h0000_005A; bus.len_i = 2'd0; bus.div_i = 4'd2;
    bus.cpol_i = 1'b1; bus.cpha_i = 1'b0; bus.lsb_first_i = 1'b0;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    toggles = 0; cyc = 0; prev_sclk = 1'b1;
    while (toggles < 5 && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.sclk_o != prev_sclk) begin
        toggles++;
        prev_sclk = bus.sclk_o;
      end
    end
    chk("rst_reach_shift", 32'(toggles), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_xfer(32'h0000_00C3, 2'd0, 4'd1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0,
            1'b0, 1'b0);

    // Randomized transfers.
    for (int unsigned it = 0; it < 24; it++) begin
      do_xfer($urandom, 2'($urandom), 4'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              $urandom, 1'b0, 1'($urandom_range(0, 3) == 0));
      if ((it % 6) == 5) do_abort(4'($urandom_range(0, 2)), 1'($urandom),
                                  1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
